// File: rtl/shift64_assembler_if.sv
// ---------------------------------------------------------------------------
// shift64_assembler_if
// Handshake bundle between a chunk source, the shift64 assembler and the
// consumer of assembled words.
//   in_valid/in_ready/in_wide/in_data : chunk input (1-bit or 8-bit chunks)
//   flush                             : request to emit the current partial word
//   out_valid/out_ready/out_data/out_count : assembled word output
//   ovf                               : pulse, an 8-bit chunk was dropped
// Modports:
//   slave  - the assembler side
//   master - the environment side (source + sink)
// ---------------------------------------------------------------------------
interface shift64_assembler_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_wide;
   logic [7:0]  in_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [6:0]  out_count;
   logic        ovf;

   modport slave (
      input  in_valid, in_wide, in_data, flush, out_ready,
      output in_ready, out_valid, out_data, out_count, ovf
   );

   modport master (
      output in_valid, in_wide, in_data, flush, out_ready,
      input  in_ready, out_valid, out_data, out_count, ovf
   );
endinterface

// File: rtl/shift64_assembler.sv
// ---------------------------------------------------------------------------
// shift64_assembler
// Serial-to-parallel assembler: shifts 1-bit or 8-bit chunks into a 64-bit
// accumulator and presents each completed (or flushed) word on a valid/ready
// output. Rebuilds words serialized by the 64-bit shifter with amount 1 or 8.
// Parameters:
//   MSB_FIRST = 1 : chunks enter at the LSB end, accumulator shifts left
//                   (first chunk ends up most significant)
//   MSB_FIRST = 0 : chunks enter at the MSB end, accumulator shifts right
//                   (first chunk ends up least significant)
// Ports:
//   clk    : rising-edge clock
//   resetn : synchronous active-low reset
//   bus    : shift64_assembler_if.slave (chunk input, flush, word output, ovf)
// ---------------------------------------------------------------------------
module shift64_assembler #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  resetn,
   shift64_assembler_if.slave    bus
);

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t      state_q,     state_d;
   logic [63:0] acc_q,       acc_d;
   logic [6:0]  cnt_q,       cnt_d;
   logic [63:0] out_data_q,  out_data_d;
   logic [6:0]  out_count_q, out_count_d;
   logic        ovf_q,       ovf_d;

   // Accumulator after shifting in a 1-bit or an 8-bit chunk
   logic [63:0] acc_sh1;
   logic [63:0] acc_sh8;

   generate
      if (MSB_FIRST) begin : g_shift_left
         assign acc_sh1 = {acc_q[62:0], bus.in_data[0]};
         assign acc_sh8 = {acc_q[55:0], bus.in_data};
      end else begin : g_shift_right
         assign acc_sh1 = {bus.in_data[0], acc_q[63:1]};
         assign acc_sh8 = {bus.in_data, acc_q[63:8]};
      end
   endgenerate

   // Post-chunk view of the accumulator, used by both completion and flush
   logic [63:0] acc_n;
   logic [6:0]  cnt_n;
   logic        drop;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      ovf_d       = 1'b0;
      acc_n       = acc_q;
      cnt_n       = cnt_q;
      drop        = 1'b0;

      case (state_q)
         ST_FILL: begin
            if (bus.in_valid) begin
               if (bus.in_wide) begin
                  // A byte only fits while at most 56 bits are held
                  if (cnt_q > 7'd56) begin
                     drop = 1'b1;
                  end else begin
                     acc_n = acc_sh8;
                     cnt_n = cnt_q + 7'd8;
                  end
               end else begin
                  acc_n = acc_sh1;
                  cnt_n = cnt_q + 7'd1;
               end
            end

            if ((cnt_n == 7'd64) || (bus.flush && (cnt_n != 7'd0))) begin
               // Emit the word; a drop coinciding with a flush is not
               // reported because ovf must stay low while a word is held
               out_data_d  = acc_n;
               out_count_d = cnt_n;
               acc_d       = 64'd0;
               cnt_d       = 7'd0;
               state_d     = ST_HOLD;
            end else begin
               acc_d = acc_n;
               cnt_d = cnt_n;
               ovf_d = drop;
            end
         end

         ST_HOLD: begin
            if (bus.out_ready) begin
               state_d = ST_FILL;
            end
         end

         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_FILL;
         acc_q       <= 64'd0;
         cnt_q       <= 7'd0;
         out_data_q  <= 64'd0;
         out_count_q <= 7'd0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         ovf_q       <= ovf_d;
      end
   end

   // in_ready depends on state only, never on in_valid
   assign bus.in_ready  = (state_q == ST_FILL);
   assign bus.out_valid = (state_q == ST_HOLD);
   assign bus.out_data  = out_data_q;
   assign bus.out_count = out_count_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_shift64_assembler.sv
// ---------------------------------------------------------------------------
// tb_shift64_assembler
// Drives one MSB_FIRST=1 and one MSB_FIRST=0 assembler with identical
// stimulus and compares both against a chunk-list reference model after
// every clock edge.
// ---------------------------------------------------------------------------
module tb_shift64_assembler;

   logic clk;
   logic resetn;

   shift64_assembler_if if_m1 ();
   shift64_assembler_if if_m0 ();

   shift64_assembler #(.MSB_FIRST(1'b1)) u_dut_m1 (
      .clk    (clk),
      .resetn (resetn),
      .bus    (if_m1.slave)
   );

   shift64_assembler #(.MSB_FIRST(1'b0)) u_dut_m0 (
      .clk    (clk),
      .resetn (resetn),
      .bus    (if_m0.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: the words are described by the list of accepted chunks
   logic [7:0]  ch_val[$];
   int          ch_w[$];
   int          m_n;
   bit          m_hold;
   bit          m_ovf;
   logic [63:0] m_data1;
   logic [63:0] m_data0;
   logic [6:0]  m_count;

   // Place chunks: MSB_FIRST=1 -> first chunk most significant, valid bits in
   // the n LSBs; MSB_FIRST=0 -> first chunk least significant, in n MSBs.
   function automatic logic [63:0] build_word(bit msb_first);
      logic [63:0] w;
      int pos;
      w = 64'd0;
      if (msb_first) begin
         pos = m_n;
         for (int i = 0; i < ch_val.size(); i++) begin
            pos -= ch_w[i];
            w |= (64'(ch_val[i]) & ((64'd1 << ch_w[i]) - 64'd1)) << pos;
         end
      end else begin
         pos = 64 - m_n;
         for (int i = 0; i < ch_val.size(); i++) begin
            w |= (64'(ch_val[i]) & ((64'd1 << ch_w[i]) - 64'd1)) << pos;
            pos += ch_w[i];
         end
      end
      return w;
   endfunction

   task automatic model_step(input bit rn, input bit iv, input bit iw,
                             input logic [7:0] d, input bit fl, input bit orr);
      bit dropped;
      if (!rn) begin
         ch_val.delete();
         ch_w.delete();
         m_n = 0; m_hold = 0; m_ovf = 0;
         m_data1 = 64'd0; m_data0 = 64'd0; m_count = 7'd0;
      end else if (m_hold) begin
         m_ovf = 0;
         if (orr) m_hold = 0;
      end else begin
         dropped = 0;
         if (iv) begin
            if (iw) begin
               if (m_n + 8 > 64) dropped = 1;
               else begin ch_val.push_back(d); ch_w.push_back(8); m_n += 8; end
            end else begin
               ch_val.push_back({7'd0, d[0]}); ch_w.push_back(1); m_n += 1;
            end
         end
         if (m_n == 64 || (fl && m_n > 0)) begin
            m_data1 = build_word(1'b1);
            m_data0 = build_word(1'b0);
            m_count = 7'(m_n);
            m_hold  = 1;
            m_ovf   = 0;
            ch_val.delete();
            ch_w.delete();
            m_n = 0;
         end else begin
            m_ovf = dropped;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("m1.in_ready",  64'(if_m1.in_ready),  64'(!m_hold));
      chk("m1.out_valid", 64'(if_m1.out_valid), 64'(m_hold));
      chk("m1.out_data",  if_m1.out_data,       m_data1);
      chk("m1.out_count", 64'(if_m1.out_count), 64'(m_count));
      chk("m1.ovf",       64'(if_m1.ovf),       64'(m_ovf));
      chk("m0.in_ready",  64'(if_m0.in_ready),  64'(!m_hold));
      chk("m0.out_valid", 64'(if_m0.out_valid), 64'(m_hold));
      chk("m0.out_data",  if_m0.out_data,       m_data0);
      chk("m0.out_count", 64'(if_m0.out_count), 64'(m_count));
      chk("m0.ovf",       64'(if_m0.ovf),       64'(m_ovf));
   endtask

   // One clock cycle: drive inputs, advance the model, sample after the edge
   task automatic step(input bit rn, input bit iv, input bit iw,
                       input logic [7:0] d, input bit fl, input bit orr);
      resetn = rn;
      if_m1.in_valid = iv; if_m1.in_wide = iw; if_m1.in_data = d;
      if_m1.flush = fl;    if_m1.out_ready = orr;
      if_m0.in_valid = iv; if_m0.in_wide = iw; if_m0.in_data = d;
      if_m0.flush = fl;    if_m0.out_ready = orr;
      model_step(rn, iv, iw, d, fl, orr);
      @(posedge clk);
      #1;
      check_all();
      $display("t=%0t rn=%0b iv=%0b iw=%0b d=%h fl=%0b ordy=%0b | ov=%0b cnt=%0d d1=%h d0=%h ovf=%0b",
               $time, rn, iv, iw, d, fl, orr, if_m1.out_valid, if_m1.out_count,
               if_m1.out_data, if_m0.out_data, if_m1.ovf);
   endtask

   logic [7:0] bytes_tbl [8];

   initial begin
      bytes_tbl[0] = 8'h01; bytes_tbl[1] = 8'h23; bytes_tbl[2] = 8'h45; bytes_tbl[3] = 8'h67;
      bytes_tbl[4] = 8'h89; bytes_tbl[5] = 8'hAB; bytes_tbl[6] = 8'hCD; bytes_tbl[7] = 8'hEF;

      resetn = 1'b0;
      if_m1.in_valid = 0; if_m1.in_wide = 0; if_m1.in_data = 0; if_m1.flush = 0; if_m1.out_ready = 0;
      if_m0.in_valid = 0; if_m0.in_wide = 0; if_m0.in_data = 0; if_m0.flush = 0; if_m0.out_ready = 0;

      // Reset state
      step(0, 0, 0, 8'h00, 0, 0);
      step(0, 1, 1, 8'hFF, 1, 1);

      // Eight bytes -> 0x0123456789ABCDEF / 0xEFCDAB8967452301
      for (int i = 0; i < 8; i++) step(1, 1, 1, bytes_tbl[i], 0, 1);
      step(1, 1, 1, 8'h55, 0, 1);   // handshake cycle, chunk must be ignored
      step(1, 0, 0, 8'h00, 0, 1);

      // 60 ones, a dropped byte, then 4 more ones
      for (int i = 0; i < 60; i++) step(1, 1, 0, 8'h01, 0, 1);
      step(1, 1, 1, 8'hFF, 0, 1);
      step(1, 0, 0, 8'h00, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 8'h01, 0, 1);
      step(1, 0, 0, 8'h00, 0, 1);

      // Flush with a same-cycle bit: 0xA5, 0x3C, 1 -> 0x14A79, 17 bits
      step(1, 1, 1, 8'hA5, 0, 1);
      step(1, 1, 1, 8'h3C, 0, 1);
      step(1, 1, 0, 8'h01, 1, 1);
      step(1, 0, 0, 8'h00, 1, 1);   // flush in HOLD ignored
      step(1, 0, 0, 8'h00, 1, 1);   // flush with cnt=0 ignored
      step(1, 0, 0, 8'h00, 0, 1);

      // Word held with out_ready=0 for 5 cycles while chunks are offered
      for (int i = 0; i < 8; i++) step(1, 1, 1, 8'($urandom), 0, 0);
      for (int i = 0; i < 5; i++) step(1, 1, 0, 8'h01, 0, 0);
      step(1, 1, 1, 8'h77, 0, 1);
      step(1, 1, 1, 8'h12, 0, 1);   // first accept after the handshake

      // Reset mid-fill at cnt=24, then a clean 64-bit word
      step(1, 1, 1, 8'h34, 0, 1);
      step(1, 1, 1, 8'h56, 0, 1);
      step(0, 1, 1, 8'h9A, 0, 1);
      for (int i = 0; i < 64; i++) step(1, 1, 0, 8'($urandom), 0, 0);
      step(1, 0, 0, 8'h00, 0, 0);
      // Reset during HOLD, then another clean word
      step(0, 0, 0, 8'h00, 0, 0);
      for (int i = 0; i < 64; i++) step(1, 1, 0, 8'($urandom), 0, 1);
      step(1, 0, 0, 8'h00, 0, 1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 3) != 0),
              1'($urandom),
              8'($urandom),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 2) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
